// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: default sizing of
// the core array and data RAM, the core index type, the request record a
// core presents to the RAM, and a small wrap-around increment helper.
// No ports (package).
package dmem_pkg;

  localparam int DMEM_CORES      = 4;
  localparam int DMEM_WIDTH      = 12;
  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH);
  localparam int DMEM_LOCK_MAX   = 4;

  typedef logic [$clog2(DMEM_CORES)-1:0] core_idx_t;

  // One core's RAM request at the default sizing.
  typedef struct packed {
    logic                       wr;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_WIDTH-1:0]      wdata;
  } mem_req_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Core-side bus between the processor core array and the data-memory
// arbiter. Every per-core field is a packed vector indexed by core number.
//   req    : per-core request, held until granted
//   wr     : per-core 1 = store, 0 = load
//   lock   : per-core request to keep the grant next cycle
//   addr   : per-core address
//   wdata  : per-core store data
//   gnt    : one-hot grant, same cycle as the RAM access
//   rvalid : one-hot, read data valid for that core
//   rdata  : shared read-data bus
// Modports: master (core array side), slave (arbiter side).
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int CORES      = DMEM_CORES,
  parameter int WIDTH      = DMEM_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);

  logic [CORES-1:0]                 req;
  logic [CORES-1:0]                 wr;
  logic [CORES-1:0]                 lock;
  logic [CORES-1:0][ADDR_WIDTH-1:0] addr;
  logic [CORES-1:0][WIDTH-1:0]      wdata;
  logic [CORES-1:0]                 gnt;
  logic [CORES-1:0]                 rvalid;
  logic [WIDTH-1:0]                 rdata;

  modport master (
    output req, wr, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker
// Purely combinational round-robin selector. Searches the request vector
// starting at ptr and wrapping modulo CORES; the first requester found wins.
//   req     in  CORES  request vector
//   ptr     in  IDX_W  index with top priority this cycle
//   gnt     out CORES  one-hot grant (all zero when nobody requests)
//   win_idx out IDX_W  index of the winner (0 when nobody requests)
//   any_gnt out 1      some core was granted
module rr_picker #(
  parameter int CORES = 4,
  parameter int IDX_W = $clog2(CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [CORES-1:0] gnt,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_gnt
);

  // Walk the ring once from ptr; the any_gnt flag stops later candidates
  // from overriding the first hit, so the result stays one-hot.
  always_comb begin
    int cand;
    gnt     = '0;
    win_idx = '0;
    any_gnt = 1'b0;
    cand    = 0;
    for (int i = 0; i < CORES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= CORES) cand = cand - CORES;
      if (!any_gnt && req[cand]) begin
        any_gnt   = 1'b1;
        gnt[cand] = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Initiator-side controller for the shared data RAM (synchronous write,
// registered-address read, one-cycle read latency). Grants one core per
// cycle with round-robin priority, drives the RAM port from the winner and
// routes read data back with a one-hot rvalid one cycle after a load grant.
//   clk        in   clock, all state on the rising edge
//   rstN       in   asynchronous active-low reset
//   bus        slave modport of dmem_arbiter_if (core-side request bus)
//   memWrEn    out  RAM write enable
//   memAddr    out  RAM address
//   memDataIn  out  RAM write data
//   memDataOut in   RAM read data
// Build option: define DMEM_ARB_LOCK_EN to let a granted core holding lock
// keep top priority for up to LOCK_MAX consecutive grants. Without it the
// lock inputs are ignored and plain round-robin applies.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int CORES      = DMEM_CORES,
  parameter int WIDTH      = DMEM_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LOCK_MAX   = DMEM_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  rstN,
  dmem_arbiter_if.slave         bus,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0]      memDataIn,
  input  logic [WIDTH-1:0]      memDataOut
);

  localparam int IDX_W = $clog2(CORES);

  // Same shape as dmem_pkg::mem_req_t but sized by this instance's params.
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } sel_req_t;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] adv_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [CORES-1:0] pick_gnt;
  logic [CORES-1:0] rvalid_q;
  logic [CORES-1:0] rvalid_next;
  logic             any_gnt;
  sel_req_t         sel;

  rr_picker #(
    .CORES (CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .win_idx (win_idx),
    .any_gnt (any_gnt)
  );

  // Mux the winner's fields onto the RAM port. With no grant win_idx is 0,
  // so the address/data lines simply show core 0 and the write enable is
  // suppressed.
  always_comb begin
    sel.wr    = bus.wr[win_idx];
    sel.addr  = bus.addr[win_idx];
    sel.wdata = bus.wdata[win_idx];
  end

  assign memWrEn    = any_gnt & sel.wr;
  assign memAddr    = sel.addr;
  assign memDataIn  = sel.wdata;
  assign bus.gnt    = pick_gnt;
  assign bus.rvalid = rvalid_q;
  // The RAM already registers the address, so its output lines up with
  // rvalid_q without another register.
  assign bus.rdata  = memDataOut;

  assign adv_ptr = IDX_W'(wrap_inc(int'(win_idx), CORES));

  // Only a granted load expects data back; its grant bit becomes next
  // cycle's rvalid.
  always_comb begin
    rvalid_next = '0;
    if (any_gnt && !sel.wr) rvalid_next = pick_gnt;
  end

  // Priority pointer and read-valid register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr      <= '0;
      rvalid_q <= '0;
    end else begin
      ptr      <= ptr_next;
      rvalid_q <= rvalid_next;
    end
  end

`ifdef DMEM_ARB_LOCK_EN

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_next;
  logic [CNT_W-1:0] run_len;
  logic             owner_vld;
  logic             owner_vld_next;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_next;

  // A locked grant keeps ptr on the winner while the run of consecutive
  // locked grants to that same core is below LOCK_MAX. The grant that
  // reaches the limit advances ptr like a normal grant. Any grant to a
  // different core, an unlocked grant or an idle cycle clears the run.
  always_comb begin
    ptr_next       = ptr;
    lock_cnt_next  = '0;
    owner_vld_next = 1'b0;
    owner_next     = '0;
    run_len        = '0;
    if (any_gnt) begin
      ptr_next = adv_ptr;
      if (bus.lock[win_idx]) begin
        run_len = (owner_vld && owner == win_idx) ? lock_cnt + 1'b1 : CNT_W'(1);
        if (run_len < CNT_W'(LOCK_MAX)) begin
          ptr_next       = win_idx;
          lock_cnt_next  = run_len;
          owner_vld_next = 1'b1;
          owner_next     = win_idx;
        end
      end
    end
  end

  // Lock run tracking.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lock_cnt  <= '0;
      owner_vld <= 1'b0;
      owner     <= '0;
    end else begin
      lock_cnt  <= lock_cnt_next;
      owner_vld <= owner_vld_next;
      owner     <= owner_next;
    end
  end

`else

  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^bus.lock;

  // Plain round-robin: the core after the winner gets top priority.
  always_comb begin
    ptr_next = ptr;
    if (any_gnt) ptr_next = adv_ptr;
  end

`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural data RAM (synchronous
// write, registered-address read). Inputs change on the falling clock edge
// and outputs are sampled 1 time unit later. A table of per-cycle vectors
// covers grant order, RAM port muxing and read return; hand-written
// sequences cover asynchronous reset mid-load and the lock rule (expected
// grants depend on whether DMEM_ARB_LOCK_EN is defined).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int CORES      = 4;
  localparam int WIDTH      = 12;
  localparam int DEPTH      = 256;
  localparam int ADDR_WIDTH = 8;
  localparam int NVEC       = 16;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  memWrEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WIDTH-1:0]      memDataIn;
  logic [WIDTH-1:0]      memDataOut;

  logic [WIDTH-1:0]      ram [DEPTH];
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [WIDTH-1:0]      ld_data;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [3:0]  lock;
    logic [31:0] addr;
    logic [47:0] wdata;
    logic [3:0]  exp_gnt;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [11:0] exp_din;
    logic [3:0]  exp_rvalid;
    logic [11:0] exp_rdata;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [3:0] lock_exp [6];

  always #5 clk = ~clk;

  dmem_arbiter_if #(
    .CORES      (CORES),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) bus ();

  dmem_arbiter #(
    .CORES      (CORES),
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LOCK_MAX   (4)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .bus        (bus),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut)
  );

  // Behavioural RAM: write at the edge, read through a registered address.
  // The ld_* port lets the bench preload contents while the DUT is in reset.
  always @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (memWrEn) ram[memAddr] <= memDataIn;
    ram_addr_q <= memAddr;
  end
  assign memDataOut = ram[ram_addr_q];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.req   = v.req;
    bus.wr    = v.wr;
    bus.lock  = v.lock;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    #1;
  endtask

  initial begin
    // Per-core fields packed {core3, core2, core1, core0}.
    //           req   wr    lock  addr          wdata              gnt   we    maddr din      rvalid rdata
    // Four loads from addresses 1..4, grants in order 0,1,2,3.
    vecs[0]  = '{4'h0, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h0, 1'b0, 8'h01, 12'h000, 4'h0, 12'h000};
    vecs[1]  = '{4'hF, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h1, 1'b0, 8'h01, 12'h000, 4'h0, 12'h000};
    vecs[2]  = '{4'hE, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h2, 1'b0, 8'h02, 12'h000, 4'h1, 12'h111};
    vecs[3]  = '{4'hC, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h4, 1'b0, 8'h03, 12'h000, 4'h2, 12'h222};
    vecs[4]  = '{4'h8, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h8, 1'b0, 8'h04, 12'h000, 4'h4, 12'h333};
    vecs[5]  = '{4'h0, 4'h0, 4'h0, 32'h04030201, 48'h000000000000, 4'h0, 1'b0, 8'h01, 12'h000, 4'h8, 12'h444};
    // Core 2 stores 0xABC at 0x10 then loads it back.
    vecs[6]  = '{4'h4, 4'h4, 4'h0, 32'h04100201, 48'h000ABC000000, 4'h4, 1'b1, 8'h10, 12'hABC, 4'h0, 12'h000};
    vecs[7]  = '{4'h4, 4'h0, 4'h0, 32'h04100201, 48'h000ABC000000, 4'h4, 1'b0, 8'h10, 12'hABC, 4'h0, 12'h000};
    vecs[8]  = '{4'h0, 4'h0, 4'h0, 32'h04100201, 48'h000ABC000000, 4'h0, 1'b0, 8'h01, 12'h000, 4'h4, 12'hABC};
    // Core 1 stores 0x555 at 7, core 3 loads 7 the next cycle.
    vecs[9]  = '{4'h2, 4'h2, 4'h0, 32'h04100701, 48'h000ABC555000, 4'h2, 1'b1, 8'h07, 12'h555, 4'h0, 12'h000};
    vecs[10] = '{4'h8, 4'h0, 4'h0, 32'h07100701, 48'h000ABC555000, 4'h8, 1'b0, 8'h07, 12'h000, 4'h0, 12'h000};
    vecs[11] = '{4'h0, 4'h0, 4'h0, 32'h07100701, 48'h000ABC555000, 4'h0, 1'b0, 8'h01, 12'h000, 4'h8, 12'h555};
    // Contended load then store back-to-back, then load of the stored word.
    vecs[12] = '{4'h3, 4'h2, 4'h0, 32'h07100201, 48'h000ABC7A5000, 4'h1, 1'b0, 8'h01, 12'h000, 4'h0, 12'h000};
    vecs[13] = '{4'h2, 4'h2, 4'h0, 32'h07100201, 48'h000ABC7A5000, 4'h2, 1'b1, 8'h02, 12'h7A5, 4'h1, 12'h111};
    vecs[14] = '{4'h1, 4'h0, 4'h0, 32'h07100202, 48'h000ABC7A5000, 4'h1, 1'b0, 8'h02, 12'h000, 4'h0, 12'h000};
    vecs[15] = '{4'h0, 4'h0, 4'h0, 32'h07100202, 48'h000ABC7A5000, 4'h0, 1'b0, 8'h02, 12'h000, 4'h1, 12'h7A5};

`ifdef DMEM_ARB_LOCK_EN
    lock_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
    lock_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

    // Reset with idle inputs and preload addresses 1..4.
    rstN      = 1'b0;
    bus.req   = '0;
    bus.wr    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    ld_we     = 1'b1;
    ld_addr   = '0;
    ld_data   = '0;
    #1;
    checkOutput("reset.rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("reset.gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset.we", 32'(memWrEn), 32'h0);
    for (int k = 0; k < 4; k++) begin
      ld_addr = ADDR_WIDTH'(k + 1);
      ld_data = 12'h111 * 12'(k + 1);
      @(posedge clk);
      #1;
    end
    ld_we = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d.gnt", i), 32'(bus.gnt), 32'(vecs[i].exp_gnt));
      checkOutput($sformatf("v%0d.we", i), 32'(memWrEn), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d.addr", i), 32'(memAddr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d.din", i), 32'(memDataIn), 32'(vecs[i].exp_din));
      checkOutput($sformatf("v%0d.rvalid", i), 32'(bus.rvalid), 32'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid != 4'h0)
        checkOutput($sformatf("v%0d.rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
    end

    // Core 1 load of address 3, then reset lands while its rvalid is up.
    @(negedge clk);
    bus.req  = 4'b0010;
    bus.wr   = 4'b0000;
    bus.lock = 4'b0000;
    bus.addr = 32'h07100301;
    #1;
    checkOutput("rst.pre_gnt", 32'(bus.gnt), 32'h2);
    checkOutput("rst.pre_addr", 32'(memAddr), 32'h03);
    @(posedge clk);
    #1;
    checkOutput("rst.pre_rvalid", 32'(bus.rvalid), 32'h2);
    bus.req = 4'b0000;
    rstN    = 1'b0;
    #1;
    checkOutput("rst.async_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("rst.gnt", 32'(bus.gnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstN    = 1'b1;
    bus.req = 4'b1010;
    #1;
    checkOutput("rst.post_gnt", 32'(bus.gnt), 32'h2);
    checkOutput("rst.post_rvalid", 32'(bus.rvalid), 32'h0);

    // Core 0 holds req+lock while core 1 keeps requesting.
    @(negedge clk);
    bus.req  = 4'b0011;
    bus.wr   = 4'b0000;
    bus.lock = 4'b0001;
    #1;
    checkOutput("lock.rvalid", 32'(bus.rvalid), 32'h2);
    checkOutput("lock.rdata", 32'(bus.rdata), 32'h333);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("lock.gnt%0d", i), 32'(bus.gnt), 32'(lock_exp[i]));
    end

    @(negedge clk);
    bus.req  = '0;
    bus.lock = '0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
